// File: rtl/divider_arbiter_pkg.sv
// Shared types and constants for the divider arbiter: FSM states, default sizes, bypass quotient.
// No logic here; latency/backpressure are properties of divider_arbiter itself.
package divider_arb_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_W     = 8;

    // Wide enough for any supported W; users truncate with W'(...).
    localparam logic [31:0] QUO_ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ACK   = 3'd3,
        RESP  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/divider_arbiter_if.sv
// Requester bundle plus divider handshake between the requesters, the arbiter and the divider.
// slave = arbiter side, master = requesters/divider side; Req/Grant and Start/Ack carry the flow control.
interface divider_arbiter_if
    import divider_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W
) ();

    logic [N_REQ-1:0]   Req;
    logic [N_REQ*W-1:0] ReqX;
    logic [N_REQ*W-1:0] ReqY;
    logic [N_REQ-1:0]   Grant;
    logic [N_REQ-1:0]   RespValid;
    logic [W-1:0]       RespQuotient;
    logic [W-1:0]       RespRemainder;
    logic               RespErr;

    logic [W-1:0]       DivX;
    logic [W-1:0]       DivY;
    logic               DivStart;
    logic               DivAck;
    logic               DivQi;
    logic               DivDone;
    logic [W-1:0]       DivQuotient;
    logic [W-1:0]       DivRemainder;

    modport slave (
        input  Req, ReqX, ReqY, DivQi, DivDone, DivQuotient, DivRemainder,
        output Grant, RespValid, RespQuotient, RespRemainder, RespErr,
        output DivX, DivY, DivStart, DivAck
    );

    modport master (
        output Req, ReqX, ReqY, DivQi, DivDone, DivQuotient, DivRemainder,
        input  Grant, RespValid, RespQuotient, RespRemainder, RespErr,
        input  DivX, DivY, DivStart, DivAck
    );

endinterface

// File: rtl/divider_arbiter_rr_arbiter.sv
// Round-robin pick: first set req at or after ptr, wrapping; one-hot grant, index and any-valid.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  id,
    output logic             any_vld
);

    always_comb begin
        int idx;
        gnt     = '0;
        id      = '0;
        any_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!any_vld && req[idx]) begin
                any_vld  = 1'b1;
                gnt[idx] = 1'b1;
                id       = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one Start/Ack divider among N_REQ requesters with round-robin grant; >=4 cycles + divider time.
// Requesters hold Req until RespValid; optional DIV_ZERO_BYPASS_EN answers Y==0 without the divider.
module divider_arbiter
    import divider_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W,
    parameter int ID_W  = $clog2(DEF_N_REQ)
) (
    input  logic             ClkPort,
    input  logic             Reset,
    divider_arbiter_if.slave bus
);

    arb_state_t       state;
    arb_state_t       state_nxt;

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_nxt;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  arb_id;
    logic [N_REQ-1:0] arb_gnt;
    logic             arb_vld;
    logic [N_REQ-1:0] grant_q;

    logic [W-1:0]     x_sel;
    logic [W-1:0]     y_sel;
    logic [W-1:0]     div_x_q;
    logic [W-1:0]     div_y_q;
    logic [W-1:0]     quo_q;
    logic [W-1:0]     rem_q;
    logic             bypass_hit;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req     (bus.Req),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .id      (arb_id),
        .any_vld (arb_vld)
    );

    assign x_sel = bus.ReqX[int'(arb_id)*W +: W];
    assign y_sel = bus.ReqY[int'(arb_id)*W +: W];

`ifdef DIV_ZERO_BYPASS_EN
    assign bypass_hit = (y_sel == '0);
`else
    assign bypass_hit = 1'b0;
`endif

    assign ptr_nxt = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;

    always_ff @(posedge ClkPort or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_vld) state_nxt = bypass_hit ? RESP : ISSUE;
            ISSUE:   if (!bus.DivQi) state_nxt = WAIT;
            WAIT:    if (bus.DivDone) state_nxt = ACK;
            ACK:     if (bus.DivQi) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are captured once at grant, so requesters may change them afterwards.
    always_ff @(posedge ClkPort or negedge Reset) begin
        if (!Reset) begin
            ptr     <= '0;
            id_q    <= '0;
            grant_q <= '0;
            div_x_q <= '0;
            div_y_q <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_vld) begin
                        grant_q <= arb_gnt;
                        id_q    <= arb_id;
                        if (bypass_hit) begin
                            quo_q <= W'(QUO_ALL_ONES);
                            rem_q <= x_sel;
                        end else begin
                            div_x_q <= x_sel;
                            div_y_q <= y_sel;
                        end
                    end
                end
                WAIT: begin
                    if (bus.DivDone) begin
                        quo_q <= bus.DivQuotient;
                        rem_q <= bus.DivRemainder;
                    end
                end
                RESP: begin
                    grant_q <= '0;
                    ptr     <= ptr_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_ZERO_BYPASS_EN
    logic err_q;

    always_ff @(posedge ClkPort or negedge Reset) begin
        if (!Reset) begin
            err_q <= 1'b0;
        end else if (state == IDLE && arb_vld) begin
            err_q <= bypass_hit;
        end
    end

    assign bus.RespErr = err_q;
`else
    assign bus.RespErr = 1'b0;
`endif

    assign bus.Grant         = grant_q;
    assign bus.RespValid     = (state == RESP) ? grant_q : '0;
    assign bus.RespQuotient  = quo_q;
    assign bus.RespRemainder = rem_q;
    assign bus.DivX          = div_x_q;
    assign bus.DivY          = div_y_q;
    assign bus.DivStart      = (state == ISSUE);
    assign bus.DivAck        = (state == ACK);

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: Start/Ack divider model, round-robin scoreboard, directed and random rounds.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_divider_arbiter;

    localparam int N = 4;
    localparam int W = 8;
`ifdef DIV_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    divider_arbiter_if #(.N_REQ(N), .W(W)) bus ();

    divider_arbiter #(.N_REQ(N), .W(W), .ID_W(2)) dut (
        .ClkPort (clk),
        .Reset   (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int m_ptr    = 0;
    int last_lat = 0;
    bit start_seen;
    logic [W-1:0] rx [N];
    logic [W-1:0] ry [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Divider model: Qi -> Qc on Start, 1..4 compute cycles, Qd until Ack, back to Qi.
    logic [1:0]   dv_st;
    int           dv_cnt;
    logic [W-1:0] dv_q, dv_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_st  <= 2'd0;
            dv_cnt <= 0;
            dv_q   <= '0;
            dv_r   <= '0;
        end else begin
            case (dv_st)
                2'd0: if (bus.DivStart) begin
                    dv_st  <= 2'd1;
                    dv_cnt <= $urandom_range(1, 4);
                    if (bus.DivY == '0) begin
                        dv_q <= '1;
                        dv_r <= bus.DivX;
                    end else begin
                        dv_q <= bus.DivX / bus.DivY;
                        dv_r <= bus.DivX % bus.DivY;
                    end
                end
                2'd1: if (dv_cnt <= 1) dv_st <= 2'd2; else dv_cnt <= dv_cnt - 1;
                2'd2: if (bus.DivAck) dv_st <= 2'd0;
                default: dv_st <= 2'd0;
            endcase
        end
    end

    assign bus.DivQi        = (dv_st == 2'd0);
    assign bus.DivDone      = (dv_st == 2'd2);
    assign bus.DivQuotient  = dv_q;
    assign bus.DivRemainder = dv_r;

    // Handshake rules: Start held until divider leaves Qi, Ack held until it returns.
    logic p_start = 1'b0, p_ack = 1'b0, p_qi = 1'b0;
    always @(negedge clk) begin
        if (rst_n && p_start && p_qi) check("start_hold", bus.DivStart, 1);
        if (rst_n && p_ack && !p_qi)  check("ack_hold", bus.DivAck, 1);
        p_start <= rst_n & bus.DivStart;
        p_ack   <= rst_n & bus.DivAck;
        p_qi    <= bus.DivQi;
    end

    function automatic int first_set(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_grant"}, bus.Grant, 0);
        check({tag, "_respvalid"}, bus.RespValid, 0);
        check({tag, "_divstart"}, bus.DivStart, 0);
        check({tag, "_divack"}, bus.DivAck, 0);
        check({tag, "_divx"}, bus.DivX, 0);
        check({tag, "_divy"}, bus.DivY, 0);
        check({tag, "_quo"}, bus.RespQuotient, 0);
        check({tag, "_rem"}, bus.RespRemainder, 0);
        check({tag, "_err"}, bus.RespErr, 0);
    endtask

    // Raise Req for every requester in mask and score each response against round-robin order.
    task automatic run_round(input logic [N-1:0] mask, input bit drop_ok);
        bit pend [N];
        bit seen_g [N];
        int left, budget, cyc, exp_id, got_id, g, idx;
        logic [W-1:0] eq, er;
        logic eerr;
        left = 0;
        for (int i = 0; i < N; i++) begin
            pend[i]   = mask[i];
            seen_g[i] = 1'b0;
            if (mask[i]) begin
                bus.ReqX[i*W +: W] = rx[i];
                bus.ReqY[i*W +: W] = ry[i];
                left++;
            end
        end
        bus.Req    = bus.Req | mask;
        cyc        = 0;
        budget     = 300;
        start_seen = 1'b0;
        while (left > 0 && budget > 0) begin
            @(negedge clk);
            cyc++;
            budget--;
            if (bus.DivStart) start_seen = 1'b1;
            if (bus.Grant != '0) begin
                check("grant_onehot", $onehot(bus.Grant), 1);
                g = first_set(bus.Grant);
                if (!seen_g[g]) begin
                    seen_g[g] = 1'b1;
                    bus.ReqX[g*W +: W] = W'($urandom);
                    bus.ReqY[g*W +: W] = W'($urandom);
                    if (drop_ok && $urandom_range(0, 1) == 1) bus.Req[g] = 1'b0;
                end
            end
            if (bus.RespValid != '0) begin
                exp_id = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (exp_id < 0 && pend[idx]) exp_id = idx;
                end
                got_id = first_set(bus.RespValid);
                check("resp_onehot", $onehot(bus.RespValid), 1);
                check("resp_id", got_id, exp_id);
                if (exp_id >= 0) begin
                    if (ry[exp_id] == '0) begin
                        eq   = '1;
                        er   = rx[exp_id];
                        eerr = BYP;
                    end else begin
                        eq   = rx[exp_id] / ry[exp_id];
                        er   = rx[exp_id] % ry[exp_id];
                        eerr = 1'b0;
                    end
                    check("resp_quo", bus.RespQuotient, eq);
                    check("resp_rem", bus.RespRemainder, er);
                    check("resp_err", bus.RespErr, eerr);
                    pend[exp_id]    = 1'b0;
                    bus.Req[exp_id] = 1'b0;
                    m_ptr = (exp_id + 1) % N;
                    left--;
                end
                if (got_id >= 0) bus.Req[got_id] = 1'b0;
                last_lat = cyc + 1;
            end
        end
        check("round_outstanding", left, 0);
        @(negedge clk);
        check("resp_pulse_end", bus.RespValid, 0);
        check("grant_release", bus.Grant, 0);
    endtask

    task automatic pulse_reset();
        rst_n   = 1'b0;
        bus.Req = '0;
        m_ptr   = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int  budget;
        bit  found, seen_start;
        logic [N-1:0] mask;

        bus.Req  = '0;
        bus.ReqX = '0;
        bus.ReqY = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("post_reset");

        // Single requester 0: 70/20 = 3 r 10.
        rx[0] = 8'd70; ry[0] = 8'd20;
        run_round(4'b0001, 1'b0);

        // All four at once from ptr 0: served 0,1,2,3.
        pulse_reset();
        rx[0] = 8'd150; ry[0] = 8'd30;
        rx[1] = 8'd140; ry[1] = 8'd40;
        rx[2] = 8'd70;  ry[2] = 8'd20;
        rx[3] = 8'd255; ry[3] = 8'd16;
        run_round(4'b1111, 1'b0);

        // Serve 1 (ptr -> 2), then 0 and 3 together: 3 must come first.
        rx[1] = 8'd100; ry[1] = 8'd7;
        run_round(4'b0010, 1'b0);
        rx[0] = 8'd200; ry[0] = 8'd9;
        rx[3] = 8'd33;  ry[3] = 8'd5;
        run_round(4'b1001, 1'b0);

        // Reset while waiting on the divider: outputs clear at once, nothing delivered.
        bus.ReqX[2*W +: W] = 8'd200;
        bus.ReqY[2*W +: W] = 8'd7;
        bus.Req = 4'b0100;
        found = 1'b0;
        seen_start = 1'b0;
        budget = 50;
        while (!found && budget > 0) begin
            @(negedge clk);
            budget--;
            if (bus.DivStart) seen_start = 1'b1;
            if (seen_start && !bus.DivStart && !bus.DivAck && bus.Grant != '0 && bus.RespValid == '0)
                found = 1'b1;
        end
        check("reached_wait", found, 1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        bus.Req = '0;
        m_ptr = 0;
        repeat (2) @(negedge clk);
        check("reset_no_resp", bus.RespValid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        rx[0] = 8'd150; ry[0] = 8'd30;
        run_round(4'b0001, 1'b0);

        // Divide by zero from requester 1.
        rx[1] = 8'd9; ry[1] = 8'd0;
        run_round(4'b0010, 1'b0);
        if (BYP) begin
            check("bypass_latency", last_lat, 2);
            check("bypass_no_start", start_seen, 0);
        end else begin
            check("div_zero_issued", start_seen, 1);
        end

        // Random rounds, including drops after grant and operand changes after capture.
        for (int r = 0; r < 25; r++) begin
            mask = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                rx[i] = W'($urandom_range(0, 255));
                ry[i] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
            end
            run_round(mask, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one Start/Ack-handshaked divider (Xin, Yin, Start, Ack, Done, Qi, Quotient, Remainder) between N_REQ independent requesters.
- Round-robin grant; captures the winner's operands and drives the divider's Start/Ack handshake through Qi→Qc→Qd→Qi.
- Returns Quotient/Remainder to the granted requester with a one-cycle valid pulse.
- Sits between the requester blocks and the divider top.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 8, operand/result width.
- ID_W, 2, width of requester index; must equal clog2(N_REQ).

Ports:
- ClkPort  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  N_REQ  per-requester request level.
- ReqX  in  N_REQ*W  dividends, requester i at [i*W +: W].
- ReqY  in  N_REQ*W  divisors, same packing.
- Grant  out  N_REQ  one-hot; high while requester owns the divider.
- RespValid  out  N_REQ  one-hot, one-cycle result pulse.
- RespQuotient  out  W  result quotient, valid with RespValid.
- RespRemainder  out  W  result remainder, valid with RespValid.
- RespErr  out  1  divide-by-zero flag, valid with RespValid.
- DivX  out  W  operand to divider Xin.
- DivY  out  W  operand to divider Yin.
- DivStart  out  1  divider Start.
- DivAck  out  1  divider Ack.
- DivQi  in  1  divider in initial state.
- DivDone  in  1  divider in done state (Qd).
- DivQuotient  in  W  divider quotient.
- DivRemainder  in  W  divider remainder.

Behaviour:
- Reset (async, Reset=0): state IDLE; all outputs 0; RR pointer 0, so requester 0 has highest priority first.
- State IDLE:
  - If any Req is high, pick the first set Req at or after ptr, wrapping.
  - Register Grant, DivX, DivY and the winner's ID; go to ISSUE.
  - DivX/DivY hold until the next grant.
- State ISSUE: DivStart=1; when DivQi=0 (divider has left Qi), drop DivStart next cycle and go to WAIT.
- State WAIT:
  - When DivDone=1, capture DivQuotient/DivRemainder into result registers and go to ACK.
  - No timeout.
- State ACK: DivAck=1 until DivQi=1, then drop DivAck and go to RESP.
- State RESP:
  - RespValid[id]=1 for exactly one cycle with registered results.
  - Grant clears, ptr = id+1 (mod N_REQ), return to IDLE.
- Minimum latency from Req to RespValid: 4 cycles plus divider compute cycles.
- Requester rules:
  - Operands must stay stable only until Grant rises; they are captured at grant.
  - The requester must drop Req in the cycle after RespValid. If Req is still high, it re-enters arbitration behind the others.
- Req deassertion while granted: no effect; the transaction completes and RespValid still pulses.
- Simultaneous Req from all requesters: served in order ptr, ptr+1, … with no starvation. Worst-case wait is N_REQ-1 transactions.
- Reset mid-operation: controller returns to IDLE immediately. The divider must be reset by the same Reset net; no partial result is delivered.
- Without the optional feature, RespErr is always 0 and Y=0 is passed to the divider.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, a winner with Y==0 goes straight to RESP.
  - Divider is untouched (DivStart and DivAck stay 0).
  - Quotient = all ones, Remainder = X, RespErr = 1.
  - Latency from Req to RespValid is 2 cycles.
- Undefined: no bypass; RespErr is tied 0.

Decomposition:
- Package divider_arb_pkg holds:
  - state enum: IDLE, ISSUE, WAIT, ACK, RESP;
  - default W and N_REQ constants;
  - all-ones quotient constant for the bypass.
- Sub-module rr_arbiter (N_REQ, ID_W):
  - inputs Req and ptr;
  - outputs one-hot grant, ID and any-valid;
  - purely combinational.
- Pointer register and FSM live in divider_arbiter.

Test Plan:
- Bench divider model: Qi→Qc on Start, compute, Qd, Qi on Ack.
- Single requester 0, X=70, Y=20 → RespValid[0] pulse, Quotient=3, Remainder=10, RespErr=0, DivStart held until DivQi=0.
- Req[0..3] all high at once, operand pairs (150,30), (140,40), (70,20), (255,16):
  - responses in order 0,1,2,3;
  - results 5/0, 3/20, 3/10, 15/15;
  - Grant always one-hot.
- ptr=2 after serving requester 1, then Req[0] and Req[3] together → requester 3 served before 0.
- Reset pulled low during WAIT → all outputs 0 asynchronously. After release, a new request 150/30 completes with 5/0.
- Requester 1, X=9, Y=0:
  - with DIV_ZERO_BYPASS_EN: RespErr=1, Quotient=8'hFF, Remainder=9, DivStart never asserted, 2-cycle latency;
  - without the macro: the request is passed to the divider and RespErr=0.
